uart_rx_buffered: RTL and testbench

UART receive front end that deserialises the `uart_rxd` line driven by the host, or by the bench's UART partner, into bytes and queues them for the LM32 system's UART peripheral. It sits directly upstream of the system's register-mapped UART RX path. Incoming 8N1 frames (optionally 8E1) are sampled at mid-bit, checked, and pushed into a first-word-fall-through FIFO with a valid/ready read port.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 70 +++++++
 rtl/uart_rx_buffered.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART receiver.
//   - rx_state_t   : receiver FSM state encoding
//   - FRAME_BITS   : bits following the start bit (data + optional parity + stop)
//   - calc_div     : bit period in clock cycles, rounded to nearest
//   - calc_half    : half bit period, used to reach the start-bit midpoint
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames when defined, 8N1 otherwise).
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int FRAME_BITS = 10;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int FRAME_BITS = 9;
`endif

  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud);
    return calc_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO for the UART receiver.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write request, push_data is the byte to store
//   pop         : read request, honoured only while valid
//   head        : oldest byte (0 while empty), valid: FIFO not empty
//   count       : occupancy, 0 .. 2**aw
//   push_drop   : combinational, high when a push is refused (full, no pop)
module uart_rx_fifo #(
  parameter int aw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          valid,
  output logic [aw:0]   count,
  output logic          push_drop
);

  localparam int DEPTH = 1 << aw;
  localparam logic [aw:0] FULL_CNT = {1'b1, {aw{1'b0}}};

  logic [7:0]    mem [DEPTH];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop_ok    = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && !push_ok;

  assign valid = !empty;
  assign head  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + aw'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (aw + 1)'(1);
        2'b01:   count <= count - (aw + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receive front end with a FWFT byte queue.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   uart_rxd    : serial input, idle high, asynchronous to clk
//   rx_data     : FIFO head byte, valid while rx_valid
//   rx_valid    : FIFO not empty
//   rx_ready    : consumer pops the head when rx_valid && rx_ready
//   rx_count    : FIFO occupancy
//   overrun     : 1-cycle pulse, complete frame dropped because FIFO full
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   parity_err  : 1-cycle pulse, parity mismatch (tied 0 without parity)
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 instead of 8N1.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000,
  parameter int fifo_aw        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rxd,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [fifo_aw:0]   rx_count,
  output logic               overrun,
  output logic               frame_err,
  output logic               parity_err
);

  localparam int DIV   = calc_div(clk_freq, uart_baud_rate);
  localparam int HALF  = calc_half(clk_freq, uart_baud_rate);
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV - 1);

  logic             rxd_meta;
  logic             rxs;
  rx_state_t        state;
  rx_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             tick;
  logic             push;
  logic             ferr_set;
  logic             push_drop;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
  logic             par_bad_n;
  logic             perr_set;
`endif

  // Stage: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxs      <= rxd_meta;
    end
  end

  assign tick = (cnt == '0);

  // Stage: receiver FSM, next-state and sample decisions
  always_comb begin
    state_n   = state;
    cnt_n     = tick ? cnt : cnt - CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_set  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_n   = HALF_LOAD;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_n     = DIV_LOAD;
            bit_idx_n = 3'd0;
            state_n   = ST_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end else begin
            // Line bounced back high before mid-start: treat as noise.
            state_n = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_n   = {rxs, shift[7:1]};
          cnt_n     = DIV_LOAD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // Even parity: data bits plus parity bit carry an even number of ones.
          par_bad_n = rxs ^ (^shift);
          cnt_n     = DIV_LOAD;
          state_n   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (!rxs) begin
            ferr_set = 1'b1;
            state_n  = ST_WAIT_IDLE;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_set = 1'b1;
            end else begin
              push = 1'b1;
            end
`else
            push = 1'b1;
`endif
            // Leaving at mid-stop leaves half a bit to catch the next start edge.
            state_n = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Stage: FSM and bit-timing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  // Stage: status pulses, registered so they land the cycle after the stop sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= push_drop;
      frame_err <= ferr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .aw (fifo_aw)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .count     (rx_count),
    .push_drop (push_drop)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered: a serial driver feeds frames, a queue-based
// reference model predicts FIFO contents and error/overrun pulse counts.
module tb_uart_rx_buffered;

  localparam int CLK_FREQ   = 100000000;
  localparam int BAUD       = 1152000;
  localparam int DIV        = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF       = DIV / 2;
  localparam int DEPTH      = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 10;
  localparam int LAT        = 2 + HALF + 8 * DIV + DIV + DIV + 1;
`else
  localparam int FRAME_BITS = 9;
  localparam int LAT        = 2 + HALF + 8 * DIV + DIV + 1;
`endif
  localparam int FRAME_CYC  = (FRAME_BITS + 1) * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  int n_ferr = 0;
  int n_ovr  = 0;
  int n_perr = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int exp_perr = 0;
  logic [7:0] model_q[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [4:0] exp_count;
    logic [7:0] exp_head;
    int         exp_ferr_inc;
  } vec_t;
  vec_t tbl[5];

  uart_rx_buffered #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD),
    .fifo_aw        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Pulse counters: a pulse held longer than one cycle counts more than once.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic par_ok();
`ifdef UART_RX_PARITY_EN
    return !par_flip;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: what a completed frame does to the queue and the pulse tallies.
  task automatic apply_model(input logic [7:0] d, input logic stop_ok, input logic parity_ok);
    if (!stop_ok) exp_ferr++;
    else if (!parity_ok) exp_perr++;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else exp_ovr++;
  endtask

  // Called on a negedge; drives one frame LSB first, each bit DIV cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic end_level);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ par_flip;
    repeat (DIV) @(negedge clk);
`endif
    uart_rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rxd = end_level;
  endtask

  task automatic do_frame(input logic [7:0] d, input logic stop_bit);
    send_frame(d, stop_bit, 1'b1);
    repeat (4) @(negedge clk);
    apply_model(d, stop_bit, par_ok());
  endtask

  task automatic compare_state(input string name);
    check({name, ".count"}, 32'(rx_count), 32'(model_q.size()));
    check({name, ".valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check({name, ".head"}, 32'(rx_data), 32'(model_q[0]));
    check({name, ".ferr"}, n_ferr, exp_ferr);
    check({name, ".ovr"}, n_ovr, exp_ovr);
    check({name, ".perr"}, n_perr, exp_perr);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp_b;
    exp_b = model_q.pop_front();
    check({name, ".valid"}, 32'(rx_valid), 32'd1);
    check({name, ".data"}, 32'(rx_data), 32'(exp_b));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    check({name, ".count"}, 32'(rx_count), 32'(model_q.size()));
    while (model_q.size() != 0) pop_check(name);
    check({name, ".empty"}, 32'(rx_count), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] rd;
    logic       st;

    tbl[0] = '{8'h00, 1'b1, 5'd1, 8'h00, 0};
    tbl[1] = '{8'hFF, 1'b1, 5'd2, 8'h00, 0};
    tbl[2] = '{8'h3C, 1'b0, 5'd2, 8'h00, 1};
    tbl[3] = '{8'h81, 1'b1, 5'd3, 8'h00, 0};
    tbl[4] = '{8'h55, 1'b0, 5'd3, 8'h00, 1};

    // Reset state
    #3;
    check("rst.valid", 32'(rx_valid), 32'd0);
    check("rst.data", 32'(rx_data), 32'd0);
    check("rst.count", 32'(rx_count), 32'd0);
    check("rst.pulses", 32'({overrun, frame_err, parity_err}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame latency
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        while (lat < 3000) begin
          @(negedge clk);
          lat++;
          if (rx_valid) break;
        end
      end
    join
    check("lat.cycles", lat, LAT);
    apply_model(8'hA5, 1'b1, 1'b1);
    compare_state("lat");
    drain("lat.drain");

    // Ready while empty is ignored
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    check("empty_pop.count", 32'(rx_count), 32'd0);

    // Table of frames from an empty FIFO
    for (int i = 0; i < 5; i++) begin
      int f0;
      f0 = n_ferr;
      send_frame(tbl[i].d, tbl[i].stop, 1'b1);
      repeat (20) @(negedge clk);
      apply_model(tbl[i].d, tbl[i].stop, 1'b1);
      check($sformatf("tbl%0d.count", i), 32'(rx_count), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d.head", i), 32'(rx_data), 32'(tbl[i].exp_head));
      check($sformatf("tbl%0d.ferr", i), n_ferr - f0, tbl[i].exp_ferr_inc);
      check($sformatf("tbl%0d.ovr", i), n_ovr, exp_ovr);
    end
    drain("tbl.drain");

    // Stop bit low then line held low: one frame error only
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (5 * FRAME_CYC) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    apply_model(8'h3C, 1'b0, 1'b1);
    compare_state("break");

    // Short low glitch on idle line
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    compare_state("glitch");
    do_frame(8'hC3, 1'b1);
    compare_state("glitch.after");
    drain("glitch.drain");

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    do_frame(8'h07, 1'b1);
    compare_state("par.bad");
    par_flip = 1'b0;
    do_frame(8'h07, 1'b1);
    compare_state("par.good");
    drain("par.drain");
`endif

    // 17 back-to-back frames, no reads
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      apply_model(8'(i), 1'b1, 1'b1);
    end
    repeat (10) @(negedge clk);
    compare_state("b2b");
    check("b2b.ovr_once", n_ovr, 1);
    drain("b2b.drain");

    // Full FIFO with pop on the push cycle
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1, 1'b1);
      apply_model(8'h20 + 8'(i), 1'b1, 1'b1);
    end
    repeat (10) @(negedge clk);
    compare_state("full");
    fork
      send_frame(8'h99, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    void'(model_q.pop_front());
    model_q.push_back(8'h99);
    compare_state("simul");
    check("simul.head", 32'(rx_data), 32'h21);
    drain("simul.drain");

    // Reset in the middle of the data bits
    do_frame(8'h11, 1'b1);
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.valid", 32'(rx_valid), 32'd0);
        check("midrst.data", 32'(rx_data), 32'd0);
        check("midrst.count", 32'(rx_count), 32'd0);
        check("midrst.pulses", 32'({overrun, frame_err, parity_err}), 32'd0);
      end
    join
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    do_frame(8'h5A, 1'b1);
    compare_state("midrst.after");
    drain("midrst.drain");

    // Randomised frames and reads against the model
    for (int i = 0; i < 24; i++) begin
      int npop;
      rd = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 7) == 0);
`endif
      do_frame(rd, st);
      compare_state($sformatf("rnd%0d", i));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (model_q.size() != 0) pop_check($sformatf("rnd%0d.pop", i));
      end
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    drain("rnd.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
